ir_cmd_scheduler: RTL

//  Sequences the IR transmitter state machine. Queues 4-bit car commands from two requesters:
//   - microprocessor bus writes to IR_ADDR
//   - a local requester (e.g. mouse/switch logic)

---
 rtl/ir_cmd_if.sv | 45 ++++
 rtl/ir_cmd_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ir_cmd_if.sv
// IR command scheduler port bundle: bus writes, local requester and IR SM link.
interface ir_cmd_if;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA;
  logic       BUS_WE;
  logic       LOC_REQ;
  logic [3:0] LOC_CMD;
  logic       LOC_ACK;
  logic       TX_BUSY;
  logic       SEND_PACKET;
  logic [3:0] COMMAND;
  logic       FIFO_FULL;
  logic       FIFO_EMPTY;
  logic       OVERFLOW;

  modport master (
    output BUS_ADDR,
    output BUS_DATA,
    output BUS_WE,
    output LOC_REQ,
    output LOC_CMD,
    input  LOC_ACK,
    output TX_BUSY,
    input  SEND_PACKET,
    input  COMMAND,
    input  FIFO_FULL,
    input  FIFO_EMPTY,
    input  OVERFLOW
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_DATA,
    input  BUS_WE,
    input  LOC_REQ,
    input  LOC_CMD,
    output LOC_ACK,
    input  TX_BUSY,
    output SEND_PACKET,
    output COMMAND,
    output FIFO_FULL,
    output FIFO_EMPTY,
    output OVERFLOW
  );
endinterface

// File: rtl/ir_cmd_scheduler.sv
// Queues IR car commands from bus and local requesters, paces packets
// on a programmable period and repeats each command REPEAT times.
module ir_cmd_scheduler #(
  parameter int          PACKET_PERIOD = 10_000_000,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          REPEAT        = 3,
  parameter logic [7:0]  IR_ADDR       = 8'h90
) (
  input  logic    CLK,
  input  logic    RESET,
  ir_cmd_if.slave ir
);

  localparam int CW = $clog2(PACKET_PERIOD);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = $clog2(REPEAT) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PACKET_PERIOD - 1);
  localparam logic [RW-1:0] REP_INIT = RW'(REPEAT - 1);
  localparam logic [7:0]    CLR_ADDR = IR_ADDR + 8'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    mem_d [FIFO_DEPTH];
  logic [3:0]    cmd_q, cmd_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          ack_q, ack_d;
  logic          ovf_q, ovf_d;

  logic          tick;
  logic          full;
  logic          empty;
  logic          pop;
  logic          send;
  logic          bus_wr;
  logic          bus_clr;
  logic          loc_try;
  logic          push_ok;
  logic          push;
  logic [3:0]    push_data;
  logic [3:0]    head;
  logic          unused_hi;

  assign unused_hi = ^ir.BUS_DATA[7:4];

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  // Bus writes win; LOC_REQ is ignored while its ack is still showing.
  always_comb begin
    bus_wr    = ir.BUS_WE && (ir.BUS_ADDR == IR_ADDR);
    bus_clr   = ir.BUS_WE && (ir.BUS_ADDR == CLR_ADDR);
    push_ok   = !full || pop;
    loc_try   = ir.LOC_REQ && !ack_q && !bus_wr;
    push      = (bus_wr || loc_try) && push_ok;
    push_data = bus_wr ? ir.BUS_DATA[3:0] : ir.LOC_CMD;
    ack_d     = loc_try && push_ok;
    ovf_d     = ovf_q || (bus_wr && !push_ok);
    if (bus_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
  end

  // Ticks seen in SEND are dropped; pacing resumes from WAIT.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rep_d   = rep_q;
    pop     = 1'b0;
    send    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick && !empty) begin
          pop     = 1'b1;
          cmd_d   = head;
          rep_d   = REP_INIT;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!ir.TX_BUSY) begin
          send    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick) begin
          if (rep_q != '0) begin
            rep_d   = rep_q - RW'(1);
            state_d = S_SEND;
          end else if (!empty) begin
            pop     = 1'b1;
            cmd_d   = head;
            rep_d   = REP_INIT;
            state_d = S_SEND;
          end else begin
            cmd_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      mem_q   <= '{default: '0};
      cmd_q   <= '0;
      rep_q   <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      mem_q   <= mem_d;
      cmd_q   <= cmd_d;
      rep_q   <= rep_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ir.LOC_ACK     = ack_q;
  assign ir.SEND_PACKET = send;
  assign ir.COMMAND     = cmd_q;
  assign ir.FIFO_FULL   = full;
  assign ir.FIFO_EMPTY  = empty;
  assign ir.OVERFLOW    = ovf_q;

endmodule
